fmap_pad_sched: RTL and testbench

// - Sequencer for one PE's feature scratch pad (the load_fmap block). Per layer: one full-pad load,

---
 rtl/fmap_pad_sched_pkg.sv | 21 ++
 rtl/fmap_pad_sched_if.sv | 49 ++++
 rtl/fmap_rd_addr_gen.sv | 67 ++++++
 rtl/fmap_pad_sched.sv | 112 +++++++++++
 tb/tb_fmap_pad_sched.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fmap_pad_sched_pkg.sv
// Shared definitions for the feature scratch-pad sequencer.
//   state_t    : FSM state encoding (3 bits, legacy-compatible constants)
//   LOAD_FULL  : load_full_cloumn value for a full-pad load command
//   LOAD_COL   : load_full_cloumn value for a single-column load command
package fmap_pad_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LDF   = 3'd1;
  localparam state_t ST_WFULL = 3'd2;
  localparam state_t ST_RD    = 3'd3;
  localparam state_t ST_LDC   = 3'd4;
  localparam state_t ST_WCOL  = 3'd5;
  localparam state_t ST_DRAIN = 3'd6;
  localparam state_t ST_DONE  = 3'd7;

  localparam logic LOAD_FULL = 1'b1;
  localparam logic LOAD_COL  = 1'b0;

endpackage

// File: rtl/fmap_pad_sched_if.sv
// Bundle of all non-clock signals of fmap_pad_sched.
//   master : PE-array controller / load_fmap / MAC side (drives config, start,
//            load handshakes and stall; receives commands, addresses, strobes)
//   slave  : the sequencer itself
// Signals:
//   layer_start, weight_num, pixel_num, load_one_cloumn_num, slide_num : layer config + start
//   fmap_ready_to_pe, load_one_cloumn_finish, pad_data_ready           : load_fmap status
//   pe_stall                                                           : MAC back-pressure
//   fmap_load_start, load_full_cloumn                                  : load command
//   raddra_ifmap, fmap_valid, window_last                              : read stream
//   busy, layer_done                                                   : layer status
interface fmap_pad_sched_if #(
  parameter int unsigned ADDRESSWIDTH_F_PAD = 8,
  parameter int unsigned ADDRESSWIDTH_W_PAD = 8,
  parameter int unsigned SLIDE_W            = 8
);

  logic                          layer_start;
  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num;
  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_num;
  logic [ADDRESSWIDTH_F_PAD-1:0] load_one_cloumn_num;
  logic [SLIDE_W-1:0]            slide_num;
  logic                          fmap_ready_to_pe;
  logic                          load_one_cloumn_finish;
  logic                          pad_data_ready;
  logic                          pe_stall;
  logic                          fmap_load_start;
  logic                          load_full_cloumn;
  logic [ADDRESSWIDTH_F_PAD-1:0] raddra_ifmap;
  logic                          fmap_valid;
  logic                          window_last;
  logic                          busy;
  logic                          layer_done;

  modport master (
    output layer_start, weight_num, pixel_num, load_one_cloumn_num, slide_num,
    output fmap_ready_to_pe, load_one_cloumn_finish, pad_data_ready, pe_stall,
    input  fmap_load_start, load_full_cloumn, raddra_ifmap, fmap_valid,
    input  window_last, busy, layer_done
  );

  modport slave (
    input  layer_start, weight_num, pixel_num, load_one_cloumn_num, slide_num,
    input  fmap_ready_to_pe, load_one_cloumn_finish, pad_data_ready, pe_stall,
    output fmap_load_start, load_full_cloumn, raddra_ifmap, fmap_valid,
    output window_last, busy, layer_done
  );

endinterface

// File: rtl/fmap_rd_addr_gen.sv
// Scratch-pad read address generator.
// Holds the window base and the in-window read counter; produces the read
// address (base + rd_cnt, wrapping on the pad size) and the 1-cycle-delayed
// data-valid / window-last strobes that line up with the RAM output.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   clear        : layer start - base and counter to 0
//   cnt_clr      : start of a new window - counter to 0
//   issue        : a read is issued this cycle
//   advance      : slide the base by col_step (same cycle as the window's last issue)
//   weight_num   : reads per window
//   col_step     : base advance per slide
//   raddr        : read address
//   issue_last   : current issue is the last read of the window
//   data_valid   : issue delayed by one cycle
//   data_last    : issue & issue_last delayed by one cycle
module fmap_rd_addr_gen #(
  parameter int unsigned ADDRESSWIDTH_F_PAD = 8,
  parameter int unsigned ADDRESSWIDTH_W_PAD = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          cnt_clr,
  input  logic                          issue,
  input  logic                          advance,
  input  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num,
  input  logic [ADDRESSWIDTH_F_PAD-1:0] col_step,
  output logic [ADDRESSWIDTH_F_PAD-1:0] raddr,
  output logic                          issue_last,
  output logic                          data_valid,
  output logic                          data_last
);

  logic [ADDRESSWIDTH_F_PAD-1:0] base;
  logic [ADDRESSWIDTH_W_PAD-1:0] rd_cnt;

  assign issue_last = (rd_cnt == weight_num - ADDRESSWIDTH_W_PAD'(1));
  // Sum kept at pad width so the window wraps around the circular pad.
  assign raddr = base + ADDRESSWIDTH_F_PAD'(rd_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base       <= '0;
      rd_cnt     <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
    end else begin
      if (clear) begin
        base   <= '0;
        rd_cnt <= '0;
      end else begin
        if (cnt_clr) begin
          rd_cnt <= '0;
        end else if (issue) begin
          rd_cnt <= issue_last ? '0 : rd_cnt + ADDRESSWIDTH_W_PAD'(1);
        end
        if (advance) begin
          base <= base + col_step;
        end
      end
      data_valid <= issue;
      data_last  <= issue & issue_last;
    end
  end

endmodule

// File: rtl/fmap_pad_sched.sv
// Feature scratch-pad sequencer for one PE.
// Per layer: one full-pad load command, then slide_num windows of weight_num
// reads each; between windows one column load is commanded and awaited.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (aborts a layer immediately)
//   bus   : fmap_pad_sched_if.slave - config/start, load_fmap handshakes,
//           pe_stall, load commands, read address, valid strobes, busy/done
module fmap_pad_sched
  import fmap_pad_sched_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH_F_PAD = 8,
  parameter int unsigned ADDRESSWIDTH_W_PAD = 8,
  parameter int unsigned SLIDE_W            = 8
) (
  input logic           clk,
  input logic           rst_n,
  fmap_pad_sched_if.slave bus
);

  state_t                        state;
  logic [ADDRESSWIDTH_W_PAD-1:0] cfg_weight_num;
  logic [ADDRESSWIDTH_F_PAD-1:0] cfg_col_step;
  logic [SLIDE_W-1:0]            cfg_slide_num;
  logic [SLIDE_W-1:0]            slide_cnt;

  logic clear;
  logic cnt_clr;
  logic issue;
  logic issue_last;
  logic win_end;
  logic final_slide;
  logic advance;
  logic col_ready;
  logic full_ready;

  // pixel_num is consumed by load_fmap itself; the sequencer only needs the
  // column step to move the window base.
  assign clear       = (state == ST_IDLE) && bus.layer_start;
  assign full_ready  = bus.pad_data_ready || bus.fmap_ready_to_pe;
  assign col_ready   = bus.load_one_cloumn_finish || bus.fmap_ready_to_pe;
  assign cnt_clr     = (state == ST_WCOL) && col_ready;
  assign issue       = (state == ST_RD) && !bus.pe_stall;
  assign win_end     = issue && issue_last;
  assign final_slide = (slide_cnt == cfg_slide_num - SLIDE_W'(1));
  assign advance     = win_end && !final_slide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cfg_weight_num <= '0;
      cfg_col_step   <= '0;
      cfg_slide_num  <= '0;
      slide_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.layer_start) begin
            cfg_weight_num <= bus.weight_num;
            cfg_col_step   <= bus.load_one_cloumn_num;
            cfg_slide_num  <= bus.slide_num;
            slide_cnt      <= '0;
            state          <= ST_LDF;
          end
        end
        ST_LDF:   state <= ST_WFULL;
        ST_WFULL: if (full_ready) state <= ST_RD;
        ST_RD: begin
          if (win_end) begin
            if (final_slide) begin
              state <= ST_DRAIN;
            end else begin
              slide_cnt <= slide_cnt + SLIDE_W'(1);
              state     <= ST_LDC;
            end
          end
        end
        ST_LDC:   state <= ST_WCOL;
        ST_WCOL:  if (col_ready) state <= ST_RD;
        ST_DRAIN: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  fmap_rd_addr_gen #(
    .ADDRESSWIDTH_F_PAD (ADDRESSWIDTH_F_PAD),
    .ADDRESSWIDTH_W_PAD (ADDRESSWIDTH_W_PAD)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .cnt_clr    (cnt_clr),
    .issue      (issue),
    .advance    (advance),
    .weight_num (cfg_weight_num),
    .col_step   (cfg_col_step),
    .raddr      (bus.raddra_ifmap),
    .issue_last (issue_last),
    .data_valid (bus.fmap_valid),
    .data_last  (bus.window_last)
  );

  // Command/status outputs decode the state register, so they drop to 0
  // together with the asynchronous reset.
  assign bus.fmap_load_start  = (state == ST_LDF) || (state == ST_LDC);
  assign bus.load_full_cloumn = (state == ST_LDF) ? LOAD_FULL : LOAD_COL;
  assign bus.busy             = (state != ST_IDLE);
  assign bus.layer_done       = (state == ST_DONE);

endmodule

// File: tb/tb_fmap_pad_sched.sv
// Self-checking bench for fmap_pad_sched: randomized layers checked against a
// queue of expected (address, window_last) reads built from the window rules.
module tb_fmap_pad_sched;

  localparam int unsigned AWF = 8;
  localparam int unsigned AWW = 8;
  localparam int unsigned SW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fmap_pad_sched_if #(
    .ADDRESSWIDTH_F_PAD (AWF),
    .ADDRESSWIDTH_W_PAD (AWW),
    .SLIDE_W            (SW)
  ) bus ();

  fmap_pad_sched #(
    .ADDRESSWIDTH_F_PAD (AWF),
    .ADDRESSWIDTH_W_PAD (AWW),
    .SLIDE_W            (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [AWF-1:0] addr;
    logic           last;
  } rd_t;

  rd_t exp_q[$];
  rd_t mon_e;

  int             cyc = 0;
  logic           mon_en = 1'b0;
  logic [AWF-1:0] prev_addr = '0;
  logic           prev_stall = 1'b0;
  int             start_cyc, done_cyc, last_valid_cyc;
  int             n_full, n_col;
  logic           done_seen;

  // Monitor: a read address seen in one cycle must come back with fmap_valid
  // in the next, in the expected order.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (bus.layer_start && !bus.busy) start_cyc = cyc;
      if (bus.fmap_valid) begin
        check("valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rd_addr", prev_addr, mon_e.addr);
          check("win_last", bus.window_last, mon_e.last);
          if (exp_q.size() == 0) last_valid_cyc = cyc;
        end
      end
      if (prev_stall) check("stall_no_valid", bus.fmap_valid, 0);
      if (bus.fmap_load_start) begin
        if (bus.load_full_cloumn) begin
          n_full++;
          check("full_load_lat", cyc, start_cyc + 1);
        end else begin
          n_col++;
        end
      end
      if (bus.layer_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        check("done_lat", cyc, last_valid_cyc + 1);
        check("done_busy", bus.busy, 1);
        check("done_q_empty", exp_q.size(), 0);
      end
    end
    prev_addr  = bus.raddra_ifmap;
    prev_stall = bus.pe_stall;
  end

  task automatic randomize_cfg_inputs();
    bus.weight_num          = AWW'($urandom);
    bus.pixel_num           = AWF'($urandom);
    bus.load_one_cloumn_num = AWF'($urandom);
    bus.slide_num           = SW'($urandom);
  endtask

  // stall_mode: 0 none, 1 random, 2 three cycles when address 5 appears
  // rdy_delay : >=0 pad_data_ready pulsed at that cycle after start only; <0 random handshakes
  task automatic run_layer(input int wn, input int col, input int sn,
                           input int stall_mode, input int rdy_delay, input bit busy_noise);
    rd_t e;
    int  stall_left;
    bit  stall_done;
    for (int s = 0; s < sn; s++) begin
      for (int r = 0; r < wn; r++) begin
        e.addr = AWF'((s * col + r) % (1 << AWF));
        e.last = (r == wn - 1);
        exp_q.push_back(e);
      end
    end
    n_full = 0; n_col = 0; done_seen = 1'b0; last_valid_cyc = -100;
    stall_left = 0; stall_done = 1'b0;
    @(posedge clk); #1;
    bus.weight_num          = AWW'(wn);
    bus.load_one_cloumn_num = AWF'(col);
    bus.slide_num           = SW'(sn);
    bus.pixel_num           = AWF'($urandom);
    bus.layer_start         = 1'b1;
    bus.pe_stall            = 1'b0;
    bus.pad_data_ready      = 1'b0;
    bus.load_one_cloumn_finish = 1'b0;
    bus.fmap_ready_to_pe    = 1'b0;
    @(posedge clk); #1;
    bus.layer_start = 1'b0;
    randomize_cfg_inputs();
    for (int t = 1; t < 4000 && !done_seen; t++) begin
      if (rdy_delay >= 0) begin
        bus.pad_data_ready   = (t == rdy_delay);
        bus.fmap_ready_to_pe = 1'b0;
      end else begin
        bus.pad_data_ready   = ($urandom_range(3) == 0);
        bus.fmap_ready_to_pe = ($urandom_range(15) == 0);
      end
      bus.load_one_cloumn_finish = ($urandom_range(3) == 0);
      case (stall_mode)
        1: bus.pe_stall = ($urandom_range(3) == 0);
        2: begin
          if (stall_left > 0) begin
            bus.pe_stall = 1'b1;
            stall_left--;
            check("stall_hold", bus.raddra_ifmap, 5);
          end else if (!stall_done && bus.raddra_ifmap == AWF'(5)) begin
            bus.pe_stall = 1'b1;
            stall_left   = 2;
            stall_done   = 1'b1;
          end else begin
            bus.pe_stall = 1'b0;
          end
        end
        default: bus.pe_stall = 1'b0;
      endcase
      if (busy_noise && $urandom_range(5) == 0) begin
        bus.layer_start = 1'b1;
        randomize_cfg_inputs();
      end else begin
        bus.layer_start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.layer_start = 1'b0;
    bus.pe_stall    = 1'b0;
    check("done_seen", done_seen, 1);
    check("busy_after", bus.busy, 0);
    check("n_full_load", n_full, 1);
    check("n_col_load", n_col, sn - 1);
    check("q_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_layer();
    bit saw;
    mon_en = 1'b0;
    @(posedge clk); #1;
    bus.weight_num = AWW'(6); bus.load_one_cloumn_num = AWF'(3); bus.slide_num = SW'(2);
    bus.layer_start = 1'b1;
    @(posedge clk); #1;
    bus.layer_start = 1'b0;
    bus.pad_data_ready = 1'b1;
    saw = 1'b0;
    for (int t = 0; t < 50 && !saw; t++) begin
      @(posedge clk); #1;
      saw = bus.fmap_valid;
    end
    check("rst_reached_rd", saw, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_outputs_zero",
          {bus.fmap_load_start, bus.load_full_cloumn, bus.raddra_ifmap, bus.fmap_valid,
           bus.window_last, bus.busy, bus.layer_done}, 0);
    bus.pad_data_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.layer_start = 1'b0;
    bus.weight_num = '0; bus.pixel_num = '0; bus.load_one_cloumn_num = '0; bus.slide_num = '0;
    bus.fmap_ready_to_pe = 1'b0; bus.load_one_cloumn_finish = 1'b0;
    bus.pad_data_ready = 1'b0; bus.pe_stall = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs",
          {bus.fmap_load_start, bus.load_full_cloumn, bus.raddra_ifmap, bus.fmap_valid,
           bus.window_last, bus.busy, bus.layer_done}, 0);
    mon_en = 1'b1;

    // single window, pad ready 5 cycles after start
    run_layer(3, 0, 1, 0, 5, 1'b0);
    check("t1_done_cycle", done_cyc, start_cyc + 5 + 3 + 2);
    // three sliding windows 0..3, 2..5, 4..7
    run_layer(4, 2, 3, 0, -1, 1'b0);
    // address wrap: second window 254,255,0,1
    run_layer(4, 254, 2, 0, -1, 1'b0);
    // three-cycle stall on address 5
    run_layer(8, 1, 1, 2, -1, 1'b0);
    // one read per window, stalls, ignored restarts while busy
    run_layer(1, 3, 4, 1, -1, 1'b1);
    run_layer(5, 7, 3, 0, -1, 1'b1);
    // asynchronous abort, then a clean layer
    reset_mid_layer();
    run_layer(4, 2, 3, 1, -1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_layer(int'($urandom_range(12, 1)), int'($urandom_range(255)),
                int'($urandom_range(6, 1)), 1, -1, bit'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
